// File: rtl/lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator
// Load/store initiator sitting between the core execute/memory stage and the
// byte-addressed data memory. One request is in flight at a time. Requests are
// screened for funct3 legality, natural alignment and address range before any
// memory access is issued; failing requests answer with an error pulse one
// cycle after acceptance.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only in IDLE, not in reset)
//   req_we, req_funct3  store/load select and RISC-V load/store funct3
//   req_addr, req_wdata byte address and store data
//   resp_valid          one-cycle response pulse
//   resp_rdata          load data (0 for stores and errors), held between pulses
//   resp_err            error qualifier for resp_valid
//   mem_addr/mem_write/mem_read/mem_wdata/mem_funct3  data memory controls
//   mem_rdata           data memory read data (registered inside the memory)
// -----------------------------------------------------------------------------
module lsu_mem_initiator #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    localparam logic [32:0] LP_LIMIT = 33'(MEM_BYTES);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [2:0]  w_bytes;
    logic        w_f3_legal;
    logic        w_misaligned;
    logic [32:0] w_last;
    logic        w_out_of_range;
    logic        w_req_err;
    logic        w_accept;
    logic        w_capture;
    logic        w_resp_valid_nxt;
    logic        w_resp_err_nxt;
    logic [31:0] w_resp_rdata_nxt;

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    // Request screening: access size, funct3 legality, alignment and range.
    always_comb begin
        w_bytes    = 3'd1;
        w_f3_legal = 1'b0;
        case (req_funct3)
            3'b000:  begin w_bytes = 3'd1; w_f3_legal = 1'b1;     end
            3'b001:  begin w_bytes = 3'd2; w_f3_legal = 1'b1;     end
            3'b010:  begin w_bytes = 3'd4; w_f3_legal = 1'b1;     end
            3'b100:  begin w_bytes = 3'd1; w_f3_legal = !req_we;  end
            3'b101:  begin w_bytes = 3'd2; w_f3_legal = !req_we;  end
            default: begin w_bytes = 3'd1; w_f3_legal = 1'b0;     end
        endcase

        if (w_bytes == 3'd2) begin
            w_misaligned = req_addr[0];
        end else if (w_bytes == 3'd4) begin
            w_misaligned = (req_addr[1:0] != 2'b00);
        end else begin
            w_misaligned = 1'b0;
        end

        // Last byte touched, in 33 bits so addresses near 2^32 cannot wrap
        // back into the legal window.
        w_last         = {1'b0, req_addr} + {30'd0, w_bytes} - 33'd1;
        w_out_of_range = (w_last >= LP_LIMIT);
        w_req_err      = !w_f3_legal || w_misaligned || w_out_of_range;
    end

    // Next-state and next-response decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_capture        = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = resp_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_req_err) begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_rdata_nxt = 32'd0;
                end else if (w_accept) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_we) begin
                    // Memory commits the write on this edge; answer now.
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = 32'd0;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // mem_rdata was registered by the memory on the previous edge.
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = mem_rdata;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, held request and registered response; reset drops any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            r_we       <= 1'b0;
            r_funct3   <= 3'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            resp_valid <= w_resp_valid_nxt;
            resp_err   <= w_resp_err_nxt;
            resp_rdata <= w_resp_rdata_nxt;
            if (w_capture) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end else begin
                r_we     <= r_we;
                r_funct3 <= r_funct3;
                r_addr   <= r_addr;
                r_wdata  <= r_wdata;
            end
        end
    end

    // Memory port decode: idle drives a harmless no-op funct3 and zeros.
    always_comb begin
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_funct3 = 3'b011;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        case (r_state)
            ST_ACCESS: begin
                mem_write  = r_we;
                mem_read   = !r_we;
                mem_funct3 = r_funct3;
                mem_addr   = r_addr;
                mem_wdata  = r_wdata;
            end
            ST_WAIT: begin
                mem_read   = 1'b1;
                mem_funct3 = r_funct3;
                mem_addr   = r_addr;
            end
            default: begin
                mem_write = 1'b0;
            end
        endcase
    end

endmodule
